// File: rtl/freq_div_scheduler.sv
// Round-robin owner of a shared FreqDivider: stop, settle, load divisor, run until released.
// Every output is a flop; the always_comb block only computes next values.
module freq_div_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int DIV_WIDTH     = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [NUM_REQ-1:0]           Req,
    input  logic [NUM_REQ*DIV_WIDTH-1:0] DivReq,
    output logic [NUM_REQ-1:0]           Grant,
    output logic                         Running,
    output logic [NUM_REQ-1:0]           IllegalReq,
    output logic [DIV_WIDTH-1:0]         DivDin,
    output logic                         DivConfig,
    output logic                         DivEnable
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DISABLE, S_CONFIG, S_RUN} state_t;

    state_t               state, nxt_state;
    logic [IW-1:0]        ptr, nxt_ptr;
    logic [IW-1:0]        owner, nxt_owner;
    logic [CW-1:0]        cnt, nxt_cnt;
    logic [DIV_WIDTH-1:0] div_lat, nxt_div;
    logic [NUM_REQ-1:0]   nxt_grant, nxt_illegal, eligible;
    logic                 nxt_running, nxt_config, nxt_enable;
    logic [DIV_WIDTH-1:0] nxt_din;
    logic [DIV_WIDTH-1:0] div_of [NUM_REQ];
    logic                 found;
    logic [IW-1:0]        pick, ptr_inc;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_div
        assign div_of[i]      = DivReq[i*DIV_WIDTH +: DIV_WIDTH];
        assign eligible[i]    = Req[i] & (div_of[i] >= DIV_WIDTH'(2));
        assign nxt_illegal[i] = Req[i] & (div_of[i] <  DIV_WIDTH'(2));
    end

    assign ptr_inc = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;

    // First eligible index at or above the pointer, wrapping around.
    always_comb begin
        int t;
        found = 1'b0;
        pick  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            t = int'(ptr) + j;
            if (t >= NUM_REQ) t = t - NUM_REQ;
            if (!found && eligible[t]) begin
                found = 1'b1;
                pick  = IW'(t);
            end
        end
    end

    always_comb begin
        nxt_state   = state;
        nxt_ptr     = ptr;
        nxt_owner   = owner;
        nxt_cnt     = cnt;
        nxt_div     = div_lat;
        nxt_grant   = Grant;
        nxt_din     = DivDin;
        nxt_running = 1'b0;
        nxt_config  = 1'b0;
        nxt_enable  = 1'b0;
        case (state)
            S_IDLE: begin
                nxt_grant = '0;
                if (found) begin
                    nxt_owner       = pick;
                    nxt_div         = div_of[pick];
                    nxt_grant[pick] = 1'b1;
                    nxt_cnt         = '0;
                    nxt_state       = S_DISABLE;
                end
            end
            S_DISABLE: begin
                if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    nxt_state  = S_CONFIG;
                    nxt_config = 1'b1;
                    nxt_din    = div_lat;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            S_CONFIG, S_RUN: begin
                nxt_state   = S_RUN;
                nxt_running = 1'b1;
                nxt_enable  = 1'b1;
            end
            default: nxt_state = S_IDLE;
        endcase
        // Release overrides everything, so an aborted sequence never pulses ConfigDiv.
        if (state != S_IDLE && !Req[owner]) begin
            nxt_state   = S_IDLE;
            nxt_grant   = '0;
            nxt_running = 1'b0;
            nxt_config  = 1'b0;
            nxt_enable  = 1'b0;
            nxt_din     = DivDin;
            nxt_ptr     = ptr_inc;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            owner      <= '0;
            cnt        <= '0;
            div_lat    <= '0;
            Grant      <= '0;
            Running    <= 1'b0;
            IllegalReq <= '0;
            DivDin     <= '0;
            DivConfig  <= 1'b0;
            DivEnable  <= 1'b0;
        end else begin
            state      <= nxt_state;
            ptr        <= nxt_ptr;
            owner      <= nxt_owner;
            cnt        <= nxt_cnt;
            div_lat    <= nxt_div;
            Grant      <= nxt_grant;
            Running    <= nxt_running;
            IllegalReq <= nxt_illegal;
            DivDin     <= nxt_din;
            DivConfig  <= nxt_config;
            DivEnable  <= nxt_enable;
        end
    end
endmodule

// File: tb/tb_freq_div_scheduler.sv
// Scoreboarded bench: rounds push the expected (owner, divisor) config order; a monitor checks pulses.
module tb_freq_div_scheduler;
    localparam int N = 4;
    localparam int W = 32;
    localparam int S = 2;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic [N-1:0]     Req = '0;
    logic [N*W-1:0]   DivReq = '0;
    logic [N-1:0]     Grant;
    logic             Running;
    logic [N-1:0]     IllegalReq;
    logic [W-1:0]     DivDin;
    logic             DivConfig;
    logic             DivEnable;

    freq_div_scheduler #(.NUM_REQ(N), .DIV_WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .DivReq(DivReq), .Grant(Grant),
        .Running(Running), .IllegalReq(IllegalReq), .DivDin(DivDin),
        .DivConfig(DivConfig), .DivEnable(DivEnable)
    );

    always #5 Clk = ~Clk;

    typedef struct {int owner; int div;} exp_t;
    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ptr_m = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: consumes one scoreboard entry per DivConfig pulse and checks the run that follows.
    int   gcnt = 0, low_cnt = 0, cur_div = 0;
    logic prev_cfg = 1'b0, prev_en = 1'b0;
    logic [N-1:0] prev_grant = '0;
    always @(negedge Clk) begin
        exp_t e;
        if (!Reset) begin
            gcnt = 0; low_cnt = 0; prev_cfg = 0; prev_en = 0; prev_grant = '0;
        end else begin
            if (Grant != 0 && prev_grant == 0) gcnt = 0;
            else if (Grant != 0) gcnt++;
            if (DivConfig) begin
                if (prev_cfg) chk("cfg_width", 2, 1);
                else if (exp_q.size() == 0) chk("cfg_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("cfg_owner", Grant, 1 << e.owner);
                    chk("cfg_din", DivDin, e.div);
                    chk("cfg_latency", gcnt, S);
                    chk("cfg_enable_low", DivEnable, 0);
                    cur_div = e.div;
                end
            end
            if (prev_cfg && Grant != 0) chk("run_after_cfg", {Running, DivEnable}, 2'b11);
            if (Running) begin
                chk("run_din_hold", DivDin, cur_div);
                chk("run_no_cfg", DivConfig, 0);
            end
            if (DivEnable != Running) chk("enable_eq_running", DivEnable, Running);
            if (DivEnable && !prev_en && low_cnt < S + 2) chk("enable_gap", low_cnt, S + 2);
            low_cnt    = DivEnable ? 0 : low_cnt + 1;
            prev_cfg   = DivConfig;
            prev_en    = DivEnable;
            prev_grant = Grant;
        end
    end

    task automatic wait_run(input int o);
        int n = 0;
        while (!(Running && Grant == N'(1 << o)) && n < 100) begin @(negedge Clk); n++; end
        if (n >= 100) chk("timeout_run", Grant, 1 << o);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Grant != 0 && n < 100) begin @(negedge Clk); n++; end
        if (n >= 100) chk("timeout_idle", Grant, 0);
    endtask

    // Reference: repeatedly grant the first remaining eligible index at/after the pointer.
    task automatic run_round(input logic [N-1:0] req_v, input logic [N*W-1:0] div_v, input bit chg);
        logic [N-1:0] elig, ill, rem;
        int ord[$];
        int d, h;
        for (int i = 0; i < N; i++) begin
            d = int'(div_v[i*W +: W]);
            elig[i] = req_v[i] && d >= 2;
            ill[i]  = req_v[i] && d < 2;
        end
        rem = elig;
        while (rem != 0) begin
            for (int j = 0; j < N; j++) begin
                int t;
                t = (ptr_m + j) % N;
                if (rem[t]) begin
                    ord.push_back(t);
                    exp_q.push_back('{owner: t, div: int'(div_v[t*W +: W])});
                    rem[t] = 1'b0;
                    ptr_m = (t + 1) % N;
                    break;
                end
            end
        end
        wait_idle();
        @(negedge Clk);
        DivReq = div_v;
        Req = req_v;
        @(negedge Clk);
        chk("illegal_mask", IllegalReq, ill);
        chk("grant_latency", Grant, (ord.size() > 0) ? (1 << ord[0]) : 0);
        foreach (ord[k]) begin
            wait_run(ord[k]);
            h = $urandom_range(1, 20);
            repeat (h) @(negedge Clk);
            if (chg) begin
                DivReq[ord[k]*W +: W] = DivReq[ord[k]*W +: W] + W'($urandom_range(1, 6));
                repeat (3) @(negedge Clk);
            end
            Req[ord[k]] = 1'b0;
            @(negedge Clk);
            wait_idle();
        end
        if (ord.size() == 0) repeat (3) @(negedge Clk);
        Req = '0;
        @(negedge Clk);
    endtask

    function automatic logic [N*W-1:0] pack4(input int d0, input int d1, input int d2, input int d3);
        return {W'(d3), W'(d2), W'(d1), W'(d0)};
    endfunction

    initial begin
        logic [N*W-1:0] dv;
        #1;
        chk("rst_outputs", {Grant, Running, IllegalReq, DivConfig, DivEnable}, 0);
        chk("rst_din", DivDin, 0);
        Req = 4'b0011; DivReq = pack4(1, 5, 0, 0);
        repeat (3) @(negedge Clk);
        chk("rst_hold", {Grant, Running, IllegalReq, DivConfig, DivEnable}, 0);
        Req = '0;
        Reset = 1'b1;
        @(negedge Clk);

        run_round(4'b0001, pack4(5, 0, 0, 0), 1'b0);
        run_round(4'b1111, pack4(3, 4, 6, 8), 1'b0);
        run_round(4'b0011, pack4(1, 7, 0, 0), 1'b0);

        // Abort during the settle phase: no pulse, and the pointer moves past the owner.
        wait_idle();
        @(negedge Clk);
        DivReq = pack4(5, 0, 0, 0); Req = 4'b0001;
        @(negedge Clk);
        chk("abort_grant", Grant, 1);
        Req = '0;
        @(negedge Clk);
        chk("abort_idle", {Grant, DivEnable, DivConfig, Running}, 0);
        repeat (6) @(negedge Clk);
        chk("abort_enable_low", DivEnable, 0);
        ptr_m = 1;
        run_round(4'b0011, pack4(5, 5, 0, 0), 1'b0);

        run_round(4'b0001, pack4(5, 0, 0, 0), 1'b1);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) dv[i*W +: W] = W'($urandom_range(0, 12));
            run_round(N'($urandom_range(0, 15)), dv, 1'($urandom_range(0, 1)));
        end

        // Async reset mid-run; pointer must restart at 0 so requester 1 beats 3.
        run_round(4'b0010, pack4(0, 4, 0, 0), 1'b0);
        wait_idle();
        exp_q.push_back('{owner: 2, div: 5});
        @(negedge Clk);
        DivReq = pack4(0, 0, 5, 0); Req = 4'b0100;
        wait_run(2);
        @(negedge Clk);
        #3 Reset = 1'b0;
        #1;
        chk("async_rst_outputs", {Grant, Running, IllegalReq, DivConfig, DivEnable}, 0);
        chk("async_rst_din", DivDin, 0);
        ptr_m = 0;
        Req = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        run_round(4'b1010, pack4(0, 4, 0, 6), 1'b0);

        repeat (5) @(negedge Clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/freq_div_scheduler.md
Name: freq_div_scheduler

Overview:
- Round-robin scheduler that shares one FreqDivider instance between NUM_REQ requesters, each wanting a different output clock ratio.
- For the winning requester it:
  - stops the divider (Enable low);
  - waits SETTLE_CYCLES;
  - loads that requester's divisor with a one-cycle ConfigDiv pulse;
  - restarts the divider and holds it until the requester releases.
- Sits directly in front of FreqDivider: its Div* outputs drive Din/ConfigDiv/Enable.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DIV_WIDTH, 32, divisor width; matches FreqDivider Din.
- SETTLE_CYCLES, 2, cycles Enable is held low before the config pulse (≥1).

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Req  in  NUM_REQ  level request per requester; held high for the whole time the divided clock is needed.
- DivReq  in  NUM_REQ*DIV_WIDTH  divisor per requester; requester i uses bits [i*DIV_WIDTH +: DIV_WIDTH].
- Grant  out  NUM_REQ  one-hot owner, registered.
- Running  out  1  divider enabled with owner's divisor, registered.
- IllegalReq  out  NUM_REQ  registered; bit i = Req[i] high with divisor <2.
- DivDin  out  DIV_WIDTH  to FreqDivider Din.
- DivConfig  out  1  to FreqDivider ConfigDiv.
- DivEnable  out  1  to FreqDivider Enable.

Behaviour:
- Reset asserted (async):
  - state IDLE; Grant=0, Running=0, IllegalReq=0, DivDin=0, DivConfig=0, DivEnable=0;
  - RR pointer=0, settle counter=0, latched divisor=0.
  - Outputs stay at these values for the whole reset time. The first evaluation happens on the first rising edge after Reset goes high.
- Eligible[i] = Req[i] & (divisor_i ≥ 2). Ineligible requesters are never granted. IllegalReq[i] is updated every cycle in every state.
- FSM states: IDLE, DISABLE, CONFIG, RUN.
- IDLE:
  - DivEnable=0, DivConfig=0, Grant=0, Running=0.
  - If any Eligible, pick the first eligible index searching upward from the pointer, wrapping around.
  - On that edge: latch index and divisor, set Grant one-hot, clear settle counter, go to DISABLE.
  - If no eligible requester, stay in IDLE.
- DISABLE:
  - DivEnable=0; Grant held.
  - Counter increments each cycle; after SETTLE_CYCLES cycles in DISABLE, go to CONFIG.
- CONFIG (exactly 1 cycle):
  - DivConfig=1, DivDin=latched divisor, DivEnable=0.
  - Then go to RUN.
- RUN:
  - DivEnable=1, Running=1, DivConfig=0; DivDin keeps the latched divisor.
  - Changes to DivReq of the owner are ignored while granted.
- Release (Req[owner] low, sampled in DISABLE, CONFIG or RUN):
  - Next edge: state IDLE; Grant=0, Running=0, DivEnable=0, DivConfig=0.
  - Pointer = owner+1 mod NUM_REQ.
  - A release during DISABLE or CONFIG aborts the sequence; a config pulse is never issued after the release is sampled.
- IDLE lasts at least 1 cycle between owners. Back-to-back handoff therefore yields DivEnable low for ≥ SETTLE_CYCLES+2 cycles.
- Latency: Req rising at edge k (sampled in IDLE) gives:
  - Grant at edge k+1;
  - DivConfig high for cycle k+1+SETTLE_CYCLES;
  - Running/DivEnable at edge k+2+SETTLE_CYCLES.
- Other requesters' Req changes during a grant have no effect until IDLE.
- Fairness: each eligible requester is granted within NUM_REQ-1 other grants.
- All outputs are registered (no combinational path from Req to Div*).

Test Plan:
- Reset then single request: Req=0001, divisor0=5 → Grant=0001 one edge after sample; DivConfig=1 with DivDin=5 for exactly one cycle, 3 edges after sample; DivEnable=Running=1 one edge later.
- Round-robin: Req=1111 held, each requester released after 20 cycles of Running → grant order 0,1,2,3,0; DivEnable low ≥4 cycles between owners; exactly one DivConfig pulse per grant carrying that owner's divisor (e.g. 3,4,6,8).
- Illegal divisor: Req=0011, divisor0=1, divisor1=7 → IllegalReq=0001, Grant=0010, DivDin=7; requester 0 is never granted.
- Abort: Req0 dropped during DISABLE (1 cycle after Grant) → IDLE next edge; no DivConfig pulse; DivEnable stays 0; pointer=1.
- Divisor change in RUN: owner's divisor changes 5→9 while Running → DivDin stays 5, no DivConfig pulse, Running stays 1.
- Async reset mid-RUN: Reset=0 between clock edges → all outputs 0 immediately. After release with Req=1000, requester 3 is granted with the full SETTLE_CYCLES sequence, pointer restarting from 0.
